vga_timing_gen: RTL

Generates the raster timing for the 1280x1024@60 Hz VGA output from the 108 MHz PLL pixel clock. The block sits directly downstream of the VGA PLL wrapper. It waits for the PLL `locked` indication to be stable before starting. It then produces registered horizontal/vertical sync, data-enable, pixel coordinates and frame/line strobes for the pixel-source and DAC stages that follow it.

---
 rtl/vga_timing_gen.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module  : vga_timing_gen
// Brief   : 1280x1024@60 raster timing generator gated by a qualified PLL lock.
// Revision: 1.0 - initial release
// ============================================================================
module vga_timing_gen #(
    parameter int   H_ACTIVE  = 1280,
    parameter int   H_FP      = 48,
    parameter int   H_SYNC    = 112,
    parameter int   H_BP      = 248,
    parameter int   V_ACTIVE  = 1024,
    parameter int   V_FP      = 1,
    parameter int   V_SYNC    = 3,
    parameter int   V_BP      = 38,
    parameter logic H_POL     = 1'b1,
    parameter logic V_POL     = 1'b1,
    parameter int   LOCK_WAIT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pll_locked,
    output logic        hsync,
    output logic        vsync,
    output logic        de,
    output logic [10:0] x,
    output logic [10:0] y,
    output logic        line_start,
    output logic        frame_start,
    output logic        running
);

    localparam int          c_H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int          c_V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam logic [10:0] c_H_LAST    = 11'(c_H_TOTAL - 1);
    localparam logic [10:0] c_V_LAST    = 11'(c_V_TOTAL - 1);
    localparam logic [10:0] c_H_ACT     = 11'(H_ACTIVE);
    localparam logic [10:0] c_V_ACT     = 11'(V_ACTIVE);
    localparam logic [10:0] c_HS_FIRST  = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] c_HS_LAST   = 11'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [10:0] c_VS_FIRST  = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] c_VS_LAST   = 11'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [7:0]  c_QUAL_LAST = 8'(LOCK_WAIT - 1);

    typedef enum logic [0:0] {
        S_WAIT_LOCK = 1'b0,
        S_RUN       = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [1:0]  r_sync;
    logic        w_lk_s;
    logic [10:0] r_h_cnt;
    logic [10:0] r_v_cnt;
    logic [10:0] w_h_nxt;
    logic [10:0] w_v_nxt;
    logic [7:0]  r_qual_cnt;
    logic [7:0]  w_qual_nxt;
    logic        w_run;

    logic        r_hsync;
    logic        r_vsync;
    logic        r_de;
    logic [10:0] r_x;
    logic [10:0] r_y;
    logic        r_line_start;
    logic        r_frame_start;
    logic        r_running;

    assign w_lk_s = r_sync[1];
    assign w_run  = (r_state == S_RUN);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync     <= 2'b00;
            r_state    <= S_WAIT_LOCK;
            r_h_cnt    <= 11'd0;
            r_v_cnt    <= 11'd0;
            r_qual_cnt <= 8'd0;
        end else begin
            r_sync     <= {r_sync[0], pll_locked};
            r_state    <= w_state_nxt;
            r_h_cnt    <= w_h_nxt;
            r_v_cnt    <= w_v_nxt;
            r_qual_cnt <= w_qual_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_h_nxt     = r_h_cnt;
        w_v_nxt     = r_v_cnt;
        w_qual_nxt  = r_qual_cnt;
        case (r_state)
            S_WAIT_LOCK: begin
                w_h_nxt = 11'd0;
                w_v_nxt = 11'd0;
                if (!w_lk_s) begin
                    w_qual_nxt = 8'd0;
                end else if (r_qual_cnt == c_QUAL_LAST) begin
                    w_state_nxt = S_RUN;
                    w_qual_nxt  = 8'd0;
                end else begin
                    w_qual_nxt = r_qual_cnt + 8'd1;
                end
            end
            S_RUN: begin
                // Any lock loss abandons the frame; the next run restarts at (0,0).
                if (!w_lk_s) begin
                    w_state_nxt = S_WAIT_LOCK;
                    w_h_nxt     = 11'd0;
                    w_v_nxt     = 11'd0;
                    w_qual_nxt  = 8'd0;
                end else if (r_h_cnt == c_H_LAST) begin
                    w_h_nxt = 11'd0;
                    w_v_nxt = (r_v_cnt == c_V_LAST) ? 11'd0 : r_v_cnt + 11'd1;
                end else begin
                    w_h_nxt = r_h_cnt + 11'd1;
                end
            end
            default: begin
                w_state_nxt = S_WAIT_LOCK;
            end
        endcase
    end

    // Every output is decoded from the same counter snapshot so they stay aligned.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hsync       <= ~H_POL;
            r_vsync       <= ~V_POL;
            r_de          <= 1'b0;
            r_x           <= 11'd0;
            r_y           <= 11'd0;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
            r_running     <= 1'b0;
        end else begin
            r_hsync       <= (w_run && r_h_cnt >= c_HS_FIRST && r_h_cnt <= c_HS_LAST) ? H_POL : ~H_POL;
            r_vsync       <= (w_run && r_v_cnt >= c_VS_FIRST && r_v_cnt <= c_VS_LAST) ? V_POL : ~V_POL;
            r_de          <= w_run && (r_h_cnt < c_H_ACT) && (r_v_cnt < c_V_ACT);
            r_x           <= w_run ? r_h_cnt : 11'd0;
            r_y           <= w_run ? r_v_cnt : 11'd0;
            r_line_start  <= w_run && (r_h_cnt == 11'd0);
            r_frame_start <= w_run && (r_h_cnt == 11'd0) && (r_v_cnt == 11'd0);
            r_running     <= w_run;
        end
    end

    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign de          = r_de;
    assign x           = r_x;
    assign y           = r_y;
    assign line_start  = r_line_start;
    assign frame_start = r_frame_start;
    assign running     = r_running;

endmodule
`default_nettype wire
